// File: rtl/moldudp64_pkg.sv
// Shared types and field positions for the MoldUDP64 header sequencer.
// Optional feature macro used by the files of this slice: MOLDUDP64_SEQ_CHECK_EN.
package moldudp64_pkg;

  localparam int unsigned DATA_W      = 64;
  localparam int unsigned SEQ_W       = 64;
  localparam int unsigned CNT_W       = 16;

  // Header field positions inside the payload beats.
  localparam int unsigned SEQ_P0_LSB  = 16;  // beat 1 [63:16]
  localparam int unsigned SEQ_P0_MSB  = 63;
  localparam int unsigned SEQ_P0_W    = SEQ_P0_MSB - SEQ_P0_LSB + 1;
  localparam int unsigned SEQ_P1_LSB  = 0;   // beat 2 [15:0]
  localparam int unsigned SEQ_P1_MSB  = 15;
  localparam int unsigned MSG_CNT_LSB = 16;  // beat 2 [31:16]
  localparam int unsigned MSG_CNT_MSB = 31;

  localparam logic [CNT_W-1:0] MSG_CNT_EOS = 16'hFFFF;

  typedef enum logic [1:0] {S_H0, S_H1, S_H2, S_MSG} hdr_state_t;

  // Decoded per-packet header fields handed to the gap checker.
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [CNT_W-1:0] cnt;
  } pkt_hdr_t;

endpackage

// File: rtl/moldudp64_seq_chk.sv
// Sequence-gap checker: compares each accepted packet's sequence number with
// the number expected from the previous packet.
// Ports: clk, nreset (async active-low), done_i (packet accepted this beat),
//        hdr_i (seq/cnt of that packet), err_gap_o (pulse, aligned with pkt_done_o),
//        exp_seq_o (expected sequence number of the next packet).
// Only instantiated when MOLDUDP64_SEQ_CHECK_EN is defined.
module moldudp64_seq_chk
  import moldudp64_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             done_i,
  input  pkt_hdr_t         hdr_i,
  output logic             err_gap_o,
  output logic [SEQ_W-1:0] exp_seq_o
);

  logic exp_valid_q;

  // First packet after reset or end-of-session only loads the expectation.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_gap_o   <= 1'b0;
      exp_seq_o   <= '0;
      exp_valid_q <= 1'b0;
    end else begin
      err_gap_o <= 1'b0;
      if (done_i) begin
        err_gap_o <= exp_valid_q && (hdr_i.seq != exp_seq_o);
        if (hdr_i.cnt == '0) begin
          exp_seq_o <= hdr_i.seq;
        end else begin
          exp_seq_o <= hdr_i.seq + SEQ_W'(hdr_i.cnt);
        end
        exp_valid_q <= (hdr_i.cnt != MSG_CNT_EOS);
      end
    end
  end

endmodule

// File: rtl/moldudp64_hdr_ctrl.sv
// MoldUDP64 header sequencer: tracks beat position in each UDP payload, drives
// the header-beat strobes, gates the message phase, captures seq/count and
// classifies packets (data / heartbeat / end-of-session / truncated).
// Ports: clk, nreset (async active-low); data_v_i/data_last_i/data_i payload stream;
//        h0_v_o/h1_v_o/h2_v_o/msg_v_o/msg_first_o combinational beat strobes;
//        msg_cnt_o/seq_num_o held header fields; pkt_done_o/heartbeat_o/eos_o and
//        err_trunc_o registered pulses.
// Macro MOLDUDP64_SEQ_CHECK_EN adds err_gap_o and exp_seq_o (sequence gap check).
module moldudp64_hdr_ctrl
  import moldudp64_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              data_v_i,
  input  logic              data_last_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              h0_v_o,
  output logic              h1_v_o,
  output logic              h2_v_o,
  output logic              msg_v_o,
  output logic              msg_first_o,
  output logic [CNT_W-1:0]  msg_cnt_o,
  output logic [SEQ_W-1:0]  seq_num_o,
  output logic              pkt_done_o,
  output logic              heartbeat_o,
  output logic              eos_o,
  output logic              err_trunc_o
`ifdef MOLDUDP64_SEQ_CHECK_EN
  ,
  output logic              err_gap_o,
  output logic [SEQ_W-1:0]  exp_seq_o
`endif
);

  hdr_state_t            state_q;
  hdr_state_t            state_d;
  logic [SEQ_P0_W-1:0]   seq_p0_q;
  logic                  beat_last;
  logic                  done_c;
  logic                  trunc_c;
  pkt_hdr_t              cur_hdr;

  assign beat_last = data_v_i & data_last_i;
  assign done_c    = beat_last & ((state_q == S_H2) | (state_q == S_MSG));
  assign trunc_c   = beat_last & ((state_q == S_H0) | (state_q == S_H1));

  // Header of the packet ending now; a header-only packet ends on the h2 beat,
  // before the held registers have captured it.
  always_comb begin
    cur_hdr.seq = seq_num_o;
    cur_hdr.cnt = msg_cnt_o;
    if (state_q == S_H2) begin
      cur_hdr.seq = {data_i[SEQ_P1_MSB:SEQ_P1_LSB], seq_p0_q};
      cur_hdr.cnt = data_i[MSG_CNT_MSB:MSG_CNT_LSB];
    end
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_H0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: advance only on valid beats; last always returns to h0.
  always_comb begin
    state_d = state_q;
    if (data_v_i) begin
      case (state_q)
        S_H0:    state_d = data_last_i ? S_H0 : S_H1;
        S_H1:    state_d = data_last_i ? S_H0 : S_H2;
        S_H2:    state_d = data_last_i ? S_H0 : S_MSG;
        S_MSG:   state_d = data_last_i ? S_H0 : S_MSG;
        default: state_d = S_H0;
      endcase
    end
  end

  // Beat strobes, aligned with data_i
  always_comb begin
    h0_v_o      = 1'b0;
    h1_v_o      = 1'b0;
    h2_v_o      = 1'b0;
    msg_v_o     = 1'b0;
    msg_first_o = 1'b0;
    if (data_v_i) begin
      h0_v_o      = (state_q == S_H0);
      h1_v_o      = (state_q == S_H1);
      h2_v_o      = (state_q == S_H2);
      msg_v_o     = (state_q == S_H2) | (state_q == S_MSG);
      msg_first_o = (state_q == S_H2);
    end
  end

  // Header capture and packet status pulses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq_p0_q    <= '0;
      msg_cnt_o   <= '0;
      seq_num_o   <= '0;
      pkt_done_o  <= 1'b0;
      heartbeat_o <= 1'b0;
      eos_o       <= 1'b0;
      err_trunc_o <= 1'b0;
    end else begin
      if (h1_v_o) begin
        seq_p0_q <= data_i[SEQ_P0_MSB:SEQ_P0_LSB];
      end
      if (h2_v_o) begin
        msg_cnt_o <= cur_hdr.cnt;
        seq_num_o <= cur_hdr.seq;
      end
      pkt_done_o  <= done_c;
      heartbeat_o <= done_c & (cur_hdr.cnt == '0);
      eos_o       <= done_c & (cur_hdr.cnt == MSG_CNT_EOS);
      err_trunc_o <= trunc_c;
    end
  end

`ifdef MOLDUDP64_SEQ_CHECK_EN
  moldudp64_seq_chk u_seq_chk (
    .clk       (clk),
    .nreset    (nreset),
    .done_i    (done_c),
    .hdr_i     (cur_hdr),
    .err_gap_o (err_gap_o),
    .exp_seq_o (exp_seq_o)
  );
`endif

  a_hdr_onehot0 : assert property (@(posedge clk) disable iff (!nreset)
    $onehot0({h0_v_o, h1_v_o, h2_v_o}));
  a_done_vs_trunc : assert property (@(posedge clk) disable iff (!nreset)
    !(pkt_done_o && err_trunc_o));

endmodule
